// File: rtl/bus_pkg.sv
// Shared core-bus definitions: load/store encodings, access sizing and load extension.
package bus_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  localparam logic [1:0] ST_SD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP,
    S_RELEASE
  } lsu_state_e;

  // Access size in bytes from the log2 size field shared by loads and stores.
  function automatic logic [3:0] size_bytes(input logic [1:0] log2_size);
    return 4'd1 << log2_size;
  endfunction

  // Contiguous low byte-lane mask for an access of the given size.
  function automatic logic [7:0] lane_fill(input logic [3:0] size);
    case (size)
      4'd1:    return 8'h01;
      4'd2:    return 8'h03;
      4'd4:    return 8'h0F;
      4'd8:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Sign or zero extension of an LSB-aligned load result.
  function automatic logic [63:0] extend(input logic [63:0] data, input logic [2:0] funct3);
    case (funct3)
      F3_LB:   return {{56{data[7]}}, data[7:0]};
      F3_LH:   return {{48{data[15]}}, data[15:0]};
      F3_LW:   return {{32{data[31]}}, data[31:0]};
      F3_LD:   return data;
      F3_LBU:  return {56'd0, data[7:0]};
      F3_LHU:  return {48'd0, data[15:0]};
      F3_LWU:  return {32'd0, data[31:0]};
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering across a two-word span: store enables/shift and load merge/shift.
module lane_align
  import bus_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic [$clog2(WORD_BYTES)-1:0] offset,
  input  logic [3:0]                    size,
  input  logic                          beat,
  input  logic [63:0]                   store_data,
  input  logic [16*WORD_BYTES-1:0]      load_merged,
  output logic [WORD_BYTES-1:0]         byte_en,
  output logic [8*WORD_BYTES-1:0]       store_word,
  output logic [63:0]                   load_data
);

  localparam int unsigned SPAN      = 2 * WORD_BYTES;
  localparam int unsigned SPAN_BITS = 8 * SPAN;
  localparam int unsigned WORD_BITS = 8 * WORD_BYTES;

  logic [SPAN-1:0]      span_mask;
  logic [SPAN_BITS-1:0] span_data;
  logic [SPAN_BITS-1:0] load_shifted;

  // Place the access in the span, then pick the half belonging to this beat.
  always_comb begin
    span_mask    = SPAN'(lane_fill(size)) << offset;
    span_data    = SPAN_BITS'(store_data) << {offset, 3'b000};
    load_shifted = load_merged >> {offset, 3'b000};
    byte_en      = beat ? span_mask[SPAN-1 -: WORD_BYTES] : span_mask[WORD_BYTES-1:0];
    store_word   = beat ? span_data[SPAN_BITS-1 -: WORD_BITS] : span_data[WORD_BITS-1:0];
    load_data    = 64'(load_shifted);
  end

endmodule

// File: rtl/bram_lsu_port.sv
// Core-bus RAM slave: window decode, sized/misaligned loads and stores over a block RAM.
module bram_lsu_port
  import bus_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [63:0] BASE       = 64'h0000_1000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [2:0]  bus_read_type,
  input  logic [1:0]  bus_write_type,
  input  logic [63:0] bus_write_data,
  output logic        selected,
  output logic [63:0] bus_read_data,
  output logic        bus_read_done,
  output logic        bus_write_done,
  output logic        fault
);

  localparam int unsigned OFF_W     = $clog2(WORD_BYTES);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned WORD_BITS = 8 * WORD_BYTES;
  localparam logic [63:0] WIN_BYTES = 64'(WORD_BYTES) * 64'(DEPTH);

  lsu_state_e state_q, state_d;

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [WORD_BITS-1:0] ram_rdata_q;
  logic [WORD_BITS-1:0] stage_q;

  logic [63:0]      rel_addr_c;
  logic [3:0]       req_size_c;
  logic             req_illegal_c;
  logic             req_split_c;
  logic             accept_c;

  logic [AW-1:0]    word_q;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       size_q;
  logic [2:0]       funct3_q;
  logic             load_q;
  logic             illegal_q;
  logic             split_q;
  logic [63:0]      wdata_q;

  logic             ram_we_c;
  logic             beat_c;
  logic [AW-1:0]    ram_word_c;
  logic             stage_we_c;
  logic [WORD_BYTES-1:0]  byte_en_c;
  logic [WORD_BITS-1:0]   store_word_c;
  logic [2*WORD_BITS-1:0] load_merged_c;
  logic [63:0]      load_data_c;

  logic [63:0]      read_data_d;
  logic             read_done_d;
  logic             write_done_d;
  logic             fault_d;

  // Window decode and request classification.
  always_comb begin
    rel_addr_c    = bus_address - BASE;
    selected      = (bus_address >= BASE) && (rel_addr_c < WIN_BYTES);
    req_size_c    = bus_read_enable ? size_bytes(bus_read_type[1:0]) : size_bytes(bus_write_type);
    req_illegal_c = (bus_read_enable && bus_write_enable)
                 || (bus_read_enable && (bus_read_type == F3_BAD))
                 || (32'(req_size_c) > WORD_BYTES)
                 || ((rel_addr_c + 64'(req_size_c)) > WIN_BYTES);
    req_split_c   = (32'(rel_addr_c[OFF_W-1:0]) + 32'(req_size_c)) > WORD_BYTES;
    accept_c      = (state_q == S_IDLE) && selected && (bus_read_enable || bus_write_enable);
  end

  // Request capture at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q    <= '0;
      off_q     <= '0;
      size_q    <= '0;
      funct3_q  <= '0;
      load_q    <= 1'b0;
      illegal_q <= 1'b0;
      split_q   <= 1'b0;
      wdata_q   <= '0;
    end else if (accept_c) begin
      word_q    <= rel_addr_c[OFF_W +: AW];
      off_q     <= rel_addr_c[OFF_W-1:0];
      size_q    <= req_size_c;
      funct3_q  <= bus_read_enable ? bus_read_type : {1'b0, bus_write_type};
      load_q    <= bus_read_enable;
      illegal_q <= req_illegal_c;
      split_q   <= req_split_c;
      wdata_q   <= bus_write_data;
    end
  end

  assign load_merged_c = split_q ? {ram_rdata_q, stage_q} : {{WORD_BITS{1'b0}}, ram_rdata_q};

  lane_align #(
    .WORD_BYTES (WORD_BYTES)
  ) u_lane_align (
    .offset      (off_q),
    .size        (size_q),
    .beat        (beat_c),
    .store_data  (wdata_q),
    .load_merged (load_merged_c),
    .byte_en     (byte_en_c),
    .store_word  (store_word_c),
    .load_data   (load_data_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, RAM controls and next output values.
  always_comb begin
    state_d      = state_q;
    ram_we_c     = 1'b0;
    beat_c       = 1'b0;
    ram_word_c   = word_q;
    stage_we_c   = 1'b0;
    read_data_d  = bus_read_data;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_BEAT0;
      end
      S_BEAT0: begin
        if (illegal_q) begin
          fault_d      = 1'b1;
          read_done_d  = load_q;
          write_done_d = !load_q;
          read_data_d  = '0;
          state_d      = S_RELEASE;
        end else begin
          ram_we_c = !load_q;
          if (split_q) begin
            state_d = S_BEAT1;
          end else if (load_q) begin
            state_d = S_RESP;
          end else begin
            write_done_d = 1'b1;
            state_d      = S_RELEASE;
          end
        end
      end
      S_BEAT1: begin
        beat_c     = 1'b1;
        ram_word_c = word_q + AW'(1);
        ram_we_c   = !load_q;
        stage_we_c = load_q;
        if (load_q) begin
          state_d = S_RESP;
        end else begin
          write_done_d = 1'b1;
          state_d      = S_RELEASE;
        end
      end
      S_RESP: begin
        read_data_d = extend(load_data_c, funct3_q);
        read_done_d = 1'b1;
        state_d     = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus_read_enable && !bus_write_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_read_data  <= '0;
      bus_read_done  <= 1'b0;
      bus_write_done <= 1'b0;
      fault          <= 1'b0;
    end else begin
      bus_read_data  <= read_data_d;
      bus_read_done  <= read_done_d;
      bus_write_done <= write_done_d;
      fault          <= fault_d;
    end
  end

  // Low word of a split load, held while the second word is read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        stage_q <= '0;
    else if (stage_we_c) stage_q <= ram_rdata_q;
  end

  // Block RAM: byte-enabled write port, registered read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (ram_we_c && byte_en_c[b]) mem[ram_word_c][8*b +: 8] <= store_word_c[8*b +: 8];
    end
    ram_rdata_q <= mem[ram_word_c];
  end

endmodule

// File: tb/tb_bram_lsu_port.sv
// Directed scoreboard bench for bram_lsu_port with a 4-byte and an 8-byte word instance.
module tb_bram_lsu_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] bus_address = '0;
  logic        bus_read_enable = 1'b0;
  logic        bus_write_enable = 1'b0;
  logic [2:0]  bus_read_type = '0;
  logic [1:0]  bus_write_type = '0;
  logic [63:0] bus_write_data = '0;

  logic        sel4, rdone4, wdone4, flt4;
  logic [63:0] rdata4;
  logic        sel8, rdone8, wdone8, flt8;
  logic [63:0] rdata8;

  localparam logic [63:0] BASE4 = 64'h1000;
  localparam logic [63:0] BASE8 = 64'h2000;
  localparam int WIN4 = 64;
  localparam int WIN8 = 128;

  typedef struct {
    logic [63:0] data;
    int          lat;
    bit          flt;
    bit          load;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  m4 [WIN4];
  logic [7:0]  m8 [WIN8];
  int          n_cmp = 0;
  int          n_bad = 0;

  bram_lsu_port #(.WORD_BYTES(4), .DEPTH(16), .BASE(BASE4), .INIT_FILE("")) dut4 (
    .clk(clk), .reset_n(reset_n), .bus_address(bus_address),
    .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
    .bus_read_type(bus_read_type), .bus_write_type(bus_write_type),
    .bus_write_data(bus_write_data), .selected(sel4), .bus_read_data(rdata4),
    .bus_read_done(rdone4), .bus_write_done(wdone4), .fault(flt4));

  bram_lsu_port #(.WORD_BYTES(8), .DEPTH(16), .BASE(BASE8), .INIT_FILE("")) dut8 (
    .clk(clk), .reset_n(reset_n), .bus_address(bus_address),
    .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
    .bus_read_type(bus_read_type), .bus_write_type(bus_write_type),
    .bus_write_data(bus_write_data), .selected(sel8), .bus_read_data(rdata8),
    .bus_read_done(rdone8), .bus_write_done(wdone8), .fault(flt8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build the expected outcome from the byte model and push it to the scoreboard.
  task automatic predict(input bit ld, input bit st, input logic [2:0] typ,
                         input logic [63:0] addr, input logic [63:0] wd, input bit wide);
    exp_t e;
    int wb, win, sz, rel, off;
    logic [63:0] v;
    wb  = wide ? 8 : 4;
    win = wide ? WIN8 : WIN4;
    sz  = 1 << typ[1:0];
    rel = int'(addr - (wide ? BASE8 : BASE4));
    off = rel % wb;
    e.load = ld;
    e.flt  = (ld && st) || (ld && typ == 3'b111) || (sz > wb) || (rel + sz > win);
    e.lat  = e.flt ? 1 : ((ld ? 2 : 1) + ((off + sz > wb) ? 1 : 0));
    v = '0;
    if (!e.flt && ld) begin
      for (int b = 0; b < sz; b++) v[8*b +: 8] = wide ? m8[rel+b] : m4[rel+b];
      if (!typ[2] && sz < 8 && v[8*sz-1]) for (int b = sz; b < 8; b++) v[8*b +: 8] = 8'hFF;
    end
    if (!e.flt && st) begin
      for (int b = 0; b < sz; b++) begin
        if (wide) m8[rel+b] = wd[8*b +: 8];
        else      m4[rel+b] = wd[8*b +: 8];
      end
    end
    e.data = v;
    sb.push_back(e);
  endtask

  // One request: drive, wait (bounded) for done, compare against the scoreboard head.
  task automatic access(input string tag, input bit ld, input bit st, input logic [2:0] typ,
                        input logic [63:0] addr, input logic [63:0] wd, input bit wide);
    exp_t e;
    int   seen;
    predict(ld, st, typ, addr, wd, wide);
    @(negedge clk);
    bus_address      = addr;
    bus_read_enable  = ld;
    bus_write_enable = st;
    bus_read_type    = typ;
    bus_write_type   = typ[1:0];
    bus_write_data   = wd;
    @(posedge clk);
    seen = 0;
    for (int n = 1; n <= 8 && seen == 0; n++) begin
      @(posedge clk); #1;
      if ((wide ? (rdone8 | wdone8) : (rdone4 | wdone4)) === 1'b1) seen = n;
    end
    e = sb.pop_front();
    check({tag, " latency"}, 64'(seen), 64'(e.lat));
    if (seen != 0) begin
      check({tag, " read_done"}, 64'(wide ? rdone8 : rdone4), 64'(e.load));
      check({tag, " write_done"}, 64'(wide ? wdone8 : wdone4), 64'(!e.load));
      check({tag, " fault"}, 64'(wide ? flt8 : flt4), 64'(e.flt));
      if (e.load || e.flt) check({tag, " data"}, wide ? rdata8 : rdata4, e.data);
      @(posedge clk); #1;
      check({tag, " single pulse"}, 64'(wide ? (rdone8 | wdone8 | flt8) : (rdone4 | wdone4 | flt4)), 64'd0);
    end
    @(negedge clk);
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    exp_t e;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", rdata4, 64'd0);
    check("reset done", 64'({rdone4, wdone4, flt4, rdone8, wdone8, flt8}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Window decode.
    bus_address = 64'h0FFF; #1; check("sel below", 64'(sel4), 64'd0);
    bus_address = 64'h1000; #1; check("sel base", 64'(sel4), 64'd1);
    bus_address = 64'h103F; #1; check("sel last", 64'(sel4), 64'd1);
    bus_address = 64'h1040; #1; check("sel end", 64'(sel4), 64'd0);

    // Initialise the words used below.
    access("init w0", 0, 1, 3'b010, BASE4 + 0,    64'h0403_0201, 0);
    access("init w1", 0, 1, 3'b010, BASE4 + 4,    64'h0807_0605, 0);
    access("init w15", 0, 1, 3'b010, BASE4 + 60,  64'hCAFE_F00D, 0);

    // Word write, byte loads.
    access("sw", 0, 1, 3'b010, BASE4 + 8, 64'hDEAD_BEEF, 0);
    access("lb", 1, 0, 3'b000, BASE4 + 11, '0, 0);
    access("lbu", 1, 0, 3'b100, BASE4 + 11, '0, 0);
    access("lh", 1, 0, 3'b001, BASE4 + 8, '0, 0);

    // Split halfword store/load and neighbour integrity.
    access("sh split", 0, 1, 3'b001, BASE4 + 3, 64'h1234, 0);
    access("lhu split", 1, 0, 3'b101, BASE4 + 3, '0, 0);
    access("lw nb0", 1, 0, 3'b010, BASE4 + 0, '0, 0);
    access("lw nb1", 1, 0, 3'b010, BASE4 + 4, '0, 0);
    access("lw split", 1, 0, 3'b010, BASE4 + 6, '0, 0);

    // 8-byte words.
    access("sd", 0, 1, 3'b011, BASE8 + 16, 64'h8000_0000_0000_0001, 1);
    access("lw8", 1, 0, 3'b010, BASE8 + 20, '0, 1);
    access("lwu8", 1, 0, 3'b110, BASE8 + 20, '0, 1);
    access("sd2", 0, 1, 3'b011, BASE8 + 24, 64'h1122_3344_5566_7788, 1);
    access("lw8 split", 1, 0, 3'b010, BASE8 + 22, '0, 1);
    access("sw8 split", 0, 1, 3'b010, BASE8 + 21, 64'hA5B6_C7D8, 1);
    access("ld8 a", 1, 0, 3'b011, BASE8 + 16, '0, 1);
    access("ld8 b", 1, 0, 3'b011, BASE8 + 24, '0, 1);

    // Illegal requests.
    access("lw past end", 1, 0, 3'b010, BASE4 + 62, '0, 0);
    access("last word kept", 1, 0, 3'b010, BASE4 + 60, '0, 0);
    access("both enables", 1, 1, 3'b010, BASE4 + 8, 64'hFFFF_FFFF, 0);
    access("after both", 1, 0, 3'b010, BASE4 + 8, '0, 0);
    access("ld narrow", 1, 0, 3'b011, BASE4 + 8, '0, 0);
    access("sd narrow", 0, 1, 3'b011, BASE4 + 8, 64'h0, 0);
    access("type 111", 1, 0, 3'b111, BASE4 + 8, '0, 0);
    access("ld8 past end", 1, 0, 3'b011, BASE8 + 124, '0, 1);

    // Held enable yields one done only.
    predict(1, 0, 3'b010, BASE4 + 8, '0, 0);
    @(negedge clk);
    bus_address = BASE4 + 8; bus_read_type = 3'b010; bus_read_enable = 1'b1;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (rdone4 === 1'b1) pulses++;
    end
    e = sb.pop_front();
    check("held pulses", 64'(pulses), 64'd1);
    check("held data", rdata4, e.data);
    @(negedge clk);
    bus_read_enable = 1'b0;
    @(negedge clk);
    access("after hold", 1, 0, 3'b100, BASE4 + 11, '0, 0);

    // Asynchronous reset during the second beat of a split load.
    @(negedge clk);
    bus_address = BASE4 + 3; bus_read_type = 3'b101; bus_read_enable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async rst rdata", rdata4, 64'd0);
    check("async rst flags", 64'({rdone4, wdone4, flt4}), 64'd0);
    @(negedge clk);
    bus_read_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    access("post reset lhu", 1, 0, 3'b101, BASE4 + 3, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
